// File: rtl/otter_mem_arbiter.sv
// Two-port arbiter for the Otter's single data-memory port (port 0 = MCU, port 1 = debug adapter).
// Optional build macro ARB_ROUND_ROBIN_EN selects round-robin tie-breaking instead of port-1 priority.
module otter_mem_arbiter #(
  parameter int RD_LATENCY = 2,
  parameter int WR_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        db_lock,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [1:0]  p0_size,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_done,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [1:0]  p1_size,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_done,
  output logic [31:0] p1_rdata,
  output logic [31:0] mem_addr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [31:0] mem_rdata
);

  localparam int CW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           owner_q, owner_d;
  logic           we_q, we_d;
  logic           p0_gnt_q, p0_gnt_d, p1_gnt_q, p1_gnt_d;
  logic           p0_done_q, p0_done_d, p1_done_q, p1_done_d;
  logic [31:0]    p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
  logic [31:0]    mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [1:0]     mem_size_q, mem_size_d;
  logic           mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
  logic           elig0_s, elig1_s, winner_s, win_we_s;

  assign elig0_s = p0_req & ~db_lock;
  assign elig1_s = p1_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_winner_q, last_winner_d;

  // On a tie, favour the port that did not win the previous grant.
  always_comb begin
    if (elig0_s && elig1_s) begin
      winner_s = ~last_winner_q;
    end else begin
      winner_s = elig1_s;
    end
  end
`else
  // Debugger wins every tie.
  always_comb begin
    winner_s = elig1_s;
  end
`endif

  assign win_we_s = winner_s ? p1_we : p0_we;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    we_d        = we_q;
    p0_gnt_d    = 1'b0;
    p1_gnt_d    = 1'b0;
    p0_done_d   = 1'b0;
    p1_done_d   = 1'b0;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_size_d  = mem_size_q;
    mem_wdata_d = mem_wdata_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_winner_d = last_winner_q;
`endif
    case (state_q)
      IDLE: begin
        if (elig0_s || elig1_s) begin
          state_d     = BUSY;
          owner_d     = winner_s;
          we_d        = win_we_s;
          p0_gnt_d    = ~winner_s;
          p1_gnt_d    = winner_s;
          mem_addr_d  = winner_s ? p1_addr  : p0_addr;
          mem_size_d  = winner_s ? p1_size  : p0_size;
          mem_wdata_d = winner_s ? p1_wdata : p0_wdata;
          mem_rd_d    = ~win_we_s;
          mem_wr_d    = win_we_s;
          cnt_d       = win_we_s ? CW'(WR_LATENCY) : CW'(RD_LATENCY);
`ifdef ARB_ROUND_ROBIN_EN
          last_winner_d = winner_s;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        // Last latency cycle: memory data is valid now, so capture straight into the owner's rdata.
        if (cnt_q == {{(CW-1){1'b0}}, 1'b1}) begin
          state_d   = DONE;
          p0_done_d = ~owner_q;
          p1_done_d = owner_q;
          if (!we_q && !owner_q) begin
            p0_rdata_d = mem_rdata;
          end else if (!we_q && owner_q) begin
            p1_rdata_d = mem_rdata;
          end else begin
            p0_rdata_d = p0_rdata_q;
          end
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= {CW{1'b0}};
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      p0_gnt_q    <= 1'b0;
      p1_gnt_q    <= 1'b0;
      p0_done_q   <= 1'b0;
      p1_done_q   <= 1'b0;
      p0_rdata_q  <= 32'h0000_0000;
      p1_rdata_q  <= 32'h0000_0000;
      mem_addr_q  <= 32'h0000_0000;
      mem_size_q  <= 2'b00;
      mem_wdata_q <= 32'h0000_0000;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_winner_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      p0_gnt_q    <= p0_gnt_d;
      p1_gnt_q    <= p1_gnt_d;
      p0_done_q   <= p0_done_d;
      p1_done_q   <= p1_done_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_size_q  <= mem_size_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_winner_q <= last_winner_d;
`endif
    end
  end

  assign p0_gnt    = p0_gnt_q;
  assign p1_gnt    = p1_gnt_q;
  assign p0_done   = p0_done_q;
  assign p1_done   = p1_done_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_size  = mem_size_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Directed self-checking bench for otter_mem_arbiter (default latencies; honours ARB_ROUND_ROBIN_EN).
module tb_otter_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        db_lock = 1'b0;
  logic        p0_req = 1'b0, p0_we = 1'b0;
  logic [1:0]  p0_size = 2'd0;
  logic [31:0] p0_addr = 32'h0, p0_wdata = 32'h0;
  logic        p1_req = 1'b0, p1_we = 1'b0;
  logic [1:0]  p1_size = 2'd0;
  logic [31:0] p1_addr = 32'h0, p1_wdata = 32'h0;
  logic [31:0] mem_rdata = 32'h0;
  logic        p0_gnt, p0_done, p1_gnt, p1_done, mem_rd, mem_wr;
  logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_wdata;
  logic [1:0]  mem_size;

  int n_checks = 0;
  int n_pass = 0;
  int exp_order[4];

  otter_mem_arbiter dut (
    .clk(clk), .reset(reset), .db_lock(db_lock),
    .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_size(mem_size), .mem_wdata(mem_wdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{1, 0, 1, 0};
`else
    exp_order = '{1, 1, 1, 1};
`endif
    do_reset();
    check("rst_p0_gnt", {31'b0, p0_gnt}, 32'd0);
    check("rst_mem_rd", {31'b0, mem_rd}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_p1_rdata", p1_rdata, 32'd0);

    // 1: port-0 read
    mem_rdata = 32'hDEAD_BEEF;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h0000_0100; p0_size = 2'd2;
    tick();
    check("t1_gnt", {31'b0, p0_gnt}, 32'd1);
    check("t1_p1_gnt", {31'b0, p1_gnt}, 32'd0);
    check("t1_mem_rd", {31'b0, mem_rd}, 32'd1);
    check("t1_mem_addr", mem_addr, 32'h0000_0100);
    p0_req = 1'b0;
    tick();
    check("t1_rd_pulse", {31'b0, mem_rd}, 32'd0);
    check("t1_early_done", {31'b0, p0_done}, 32'd0);
    tick();
    check("t1_done", {31'b0, p0_done}, 32'd1);
    check("t1_rdata", p0_rdata, 32'hDEAD_BEEF);
    check("t1_p1_done", {31'b0, p1_done}, 32'd0);
    tick();
    check("t1_done_pulse", {31'b0, p0_done}, 32'd0);
    check("t1_rdata_hold", p0_rdata, 32'hDEAD_BEEF);

    // 2: port-1 write
    mem_rdata = 32'hFFFF_0000;
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h0000_2000; p1_wdata = 32'h1234_5678; p1_size = 2'd2;
    tick();
    check("t2_gnt", {31'b0, p1_gnt}, 32'd1);
    check("t2_mem_wr", {31'b0, mem_wr}, 32'd1);
    check("t2_mem_rd", {31'b0, mem_rd}, 32'd0);
    check("t2_mem_addr", mem_addr, 32'h0000_2000);
    check("t2_mem_wdata", mem_wdata, 32'h1234_5678);
    check("t2_mem_size", {30'b0, mem_size}, 32'd2);
    p1_req = 1'b0;
    tick();
    check("t2_done", {31'b0, p1_done}, 32'd1);
    check("t2_wr_pulse", {31'b0, mem_wr}, 32'd0);
    check("t2_p1_rdata", p1_rdata, 32'd0);
    check("t2_p0_rdata", p0_rdata, 32'hDEAD_BEEF);
    tick();

    // 3: simultaneous requests after reset (port 1 wins in both builds)
    do_reset();
    mem_rdata = 32'hCAFE_F00D;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h0000_0010;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h0000_0020;
    tick();
    check("t3_p1_gnt", {31'b0, p1_gnt}, 32'd1);
    check("t3_p0_gnt_t1", {31'b0, p0_gnt}, 32'd0);
    check("t3_addr", mem_addr, 32'h0000_0020);
    p1_req = 1'b0;
    tick();
    tick();
    check("t3_p1_done", {31'b0, p1_done}, 32'd1);
    check("t3_p1_rdata", p1_rdata, 32'hCAFE_F00D);
    check("t3_p0_done", {31'b0, p0_done}, 32'd0);
    tick();
    check("t3_p0_gnt_t4", {31'b0, p0_gnt}, 32'd0);
    tick();
    check("t3_p0_gnt_t5", {31'b0, p0_gnt}, 32'd1);
    check("t3_addr2", mem_addr, 32'h0000_0010);
    p0_req = 1'b0;
    tick();
    tick();
    check("t3_p0_done", {31'b0, p0_done}, 32'd1);
    check("t3_p0_rdata", p0_rdata, 32'hCAFE_F00D);
    tick();

    // 4: both ports keep re-requesting
    do_reset();
    p0_req = 1'b1; p1_req = 1'b1; p0_we = 1'b0; p1_we = 1'b0;
    for (int t = 0; t < 4; t++) begin
      int  w;
      bit  seen;
      seen = 1'b0;
      w = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
        tick();
        if (p0_gnt || p1_gnt) begin
          seen = 1'b1;
          w = p1_gnt ? 1 : 0;
          check("t4_one_gnt", {31'b0, p0_gnt & p1_gnt}, 32'd0);
        end
      end
      check("t4_gnt_seen", {31'b0, seen}, 32'd1);
      check("t4_order", w, exp_order[t]);
      if (w == 1) p1_req = 1'b0;
      else p0_req = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        tick();
        if (p0_done || p1_done) seen = 1'b1;
      end
      check("t4_done_seen", {31'b0, seen}, 32'd1);
      p0_req = 1'b1;
      p1_req = 1'b1;
    end
    p0_req = 1'b0; p1_req = 1'b0;

    // 5: db_lock blocks port 0 until released
    do_reset();
    begin
      int g0;
      g0 = 0;
      db_lock = 1'b1;
      p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h0000_0040; p0_wdata = 32'h55AA_55AA; p0_size = 2'd0;
      for (int c = 0; c < 10; c++) begin
        tick();
        if (p0_gnt) g0++;
      end
      check("t5_locked_no_gnt", g0, 32'd0);
    end
    db_lock = 1'b0;
    tick();
    check("t5_gnt", {31'b0, p0_gnt}, 32'd1);
    check("t5_mem_wr", {31'b0, mem_wr}, 32'd1);
    check("t5_wdata", mem_wdata, 32'h55AA_55AA);
    check("t5_size", {30'b0, mem_size}, 32'd0);
    p0_req = 1'b0;
    tick();
    check("t5_done", {31'b0, p0_done}, 32'd1);
    tick();

    // 6: reset in the first busy cycle abandons the read
    do_reset();
    mem_rdata = 32'h0BAD_0BAD;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h0000_0300; p0_size = 2'd2;
    tick();
    check("t6_gnt", {31'b0, p0_gnt}, 32'd1);
    p0_req = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_gnt_clr", {31'b0, p0_gnt}, 32'd0);
    check("t6_mem_rd", {31'b0, mem_rd}, 32'd0);
    check("t6_mem_addr", mem_addr, 32'd0);
    check("t6_done_clr", {31'b0, p0_done}, 32'd0);
    begin
      int d0;
      d0 = 0;
      for (int c = 0; c < 6; c++) begin
        tick();
        if (p0_done) d0++;
      end
      check("t6_no_done", d0, 32'd0);
      check("t6_rdata", p0_rdata, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
